// File: rtl/rgb_pwm_mux_ctrl.sv
// rgb_pwm_mux_ctrl: per-channel selectable enable gating a glitch-free PWM.
// Define RGB_PWM_SYNC_IN_EN to put 2-flop synchronisers on sel and mux_inp.
module rgb_pwm_mux_ctrl #(
  parameter int CH       = 3,
  parameter int SEL_W    = 2,
  parameter int PWM_W    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SEL_W-1:0]                    sel,
  input  logic [CH*(2**SEL_W)-1:0]            mux_inp,
  input  logic                                duty_wr,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] duty_ch,
  input  logic [PWM_W-1:0]                    duty_val,
  output logic [CH-1:0]                       led_out,
  output logic                                period_tick
);
  localparam int N    = 2**SEL_W;
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0]    ps;
  logic [PWM_W-1:0]   cnt;
  logic               tick, wrap, wr_ok;
  logic [SEL_W-1:0]   sel_s;
  logic [CH*N-1:0]    mux_s;
  assign tick  = ps == PS_W'(PRESCALE - 1);
  assign wrap  = tick && cnt == '1;
  assign wr_ok = duty_wr && ({1'b0, duty_ch} < (CH_W + 1)'(CH));
  always_ff @(posedge clk) begin
    if (rst) begin
      ps          <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      ps          <= tick ? '0 : ps + 1'b1;
      cnt         <= cnt + PWM_W'(tick);
      period_tick <= wrap;
    end
  end
`ifdef RGB_PWM_SYNC_IN_EN
  logic [SEL_W-1:0] sel_m;
  logic [CH*N-1:0]  mux_m;
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_m <= '0;
      sel_s <= '0;
      mux_m <= '0;
      mux_s <= '0;
    end else begin
      sel_m <= sel;
      sel_s <= sel_m;
      mux_m <= mux_inp;
      mux_s <= mux_m;
    end
  end
`else
  assign sel_s = sel;
  assign mux_s = mux_inp;
`endif
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [PWM_W-1:0] shadow, active;
    logic [N-1:0]     cand;
    logic             hit, led_q;
    assign cand       = mux_s[c*N +: N];
    assign hit        = wr_ok && duty_ch == CH_W'(c);
    assign led_out[c] = led_q;
    // a write landing on the wrap edge bypasses the shadow so the new period uses it
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow <= '0;
        active <= '0;
        led_q  <= 1'b0;
      end else begin
        if (hit) shadow <= duty_val;
        if (wrap) active <= hit ? duty_val : shadow;
        led_q <= cand[sel_s] && cnt < active;
      end
    end
  end
endmodule
